// File: rtl/aes_vector_driver.sv
// aes_vector_driver: walks a ROM of AES test vectors and sends each one as a text
// beat followed by a key beat (tlast). Each result is checked against the expected
// ciphertext. Pass, fail and timeout status is kept for on-chip probing.
module aes_vector_driver #(
  parameter int DATA_W      = 128,
  parameter int ID_W        = 32,
  parameter int NUM_VEC     = 16,
  parameter int ADDR_W      = 4,
  parameter int TID_BASE    = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              start,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_text,
  input  logic [DATA_W-1:0] vec_key,
  input  logic [DATA_W-1:0] vec_expect,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready,
  output logic [ID_W-1:0]   tid,
  output logic [DATA_W-1:0] tdata,
  input  logic              ovalid,
  input  logic [ID_W-1:0]   oid,
  input  logic [DATA_W-1:0] odata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout_err,
  output logic [ID_W-1:0]   last_fail_id
);

  localparam int                TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);
  localparam logic [ID_W-1:0]   TID_INIT  = ID_W'(TID_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    TEXT  = 3'd2,
    KEY   = 3'd3,
    WAIT  = 3'd4,
    CHECK = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] text_r;
  logic [DATA_W-1:0] key_r;
  logic [DATA_W-1:0] exp_r;
  logic              match_r;
  logic [TO_W-1:0]   to_cnt;
  logic              last_vec;
  logic              to_hit;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign last_vec = (vec_addr == LAST_ADDR);
  assign to_hit   = (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge sclk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and stream outputs; tdata is zero whenever no beat is offered.
  always_comb begin
    state_d = state_q;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = TEXT;
      TEXT: begin
        tvalid = 1'b1;
        tdata  = text_r;
        if (tready) state_d = KEY;
      end
      KEY: begin
        tvalid = 1'b1;
        tlast  = 1'b1;
        tdata  = key_r;
        if (tready) state_d = WAIT;
      end
      WAIT:  if (ovalid || to_hit) state_d = CHECK;
      CHECK: state_d = (!last_vec || loop_en) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Vector payload, result match flag and timeout counter (no reset needed:
  // each is loaded before it is used).
  always_ff @(posedge sclk) begin
    if (state_q == FETCH) begin
      text_r <= vec_text;
      key_r  <= vec_key;
      exp_r  <= vec_expect;
    end
    if (state_q == KEY && tready) to_cnt <= '0;
    if (state_q == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
      if (ovalid)      match_r <= (oid == tid) && (odata == exp_r);
      else if (to_hit) match_r <= 1'b0;
    end
  end

  // Sequencing control, vector id/address and status counters.
  always_ff @(posedge sclk) begin
    if (srst) begin
      vec_addr     <= '0;
      tid          <= TID_INIT;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      timeout_err  <= 1'b0;
      last_fail_id <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_err  <= 1'b0;
            last_fail_id <= '0;
            vec_addr     <= '0;
            tid          <= TID_INIT;
            busy         <= 1'b1;
          end
        end
        WAIT: begin
          if (!ovalid && to_hit) timeout_err <= 1'b1;
        end
        CHECK: begin
          if (match_r) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt     <= sat_inc(fail_cnt);
            last_fail_id <= tid;
          end
          if (!last_vec) begin
            vec_addr <= vec_addr + 1'b1;
            tid      <= tid + 1'b1;
          end else if (loop_en) begin
            vec_addr <= '0;
            tid      <= tid + 1'b1;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_vector_driver.sv
// Bench for aes_vector_driver: a 4-entry vector ROM plus a behavioural aes
// stand-in that answers each key beat after a fixed latency, with per-vector
// controls to corrupt the result, corrupt the id, or stay silent.
module tb_aes_vector_driver;

  localparam int DW  = 128;
  localparam int IW  = 32;
  localparam int LAT = 3;

  logic          sclk = 1'b0;
  logic          srst, start, loop_en, tready;
  logic [1:0]    vec_addr;
  logic [DW-1:0] vec_text, vec_key, vec_expect;
  logic          tvalid, tlast;
  logic [IW-1:0] tid;
  logic [DW-1:0] tdata;
  logic          ovalid;
  logic [IW-1:0] oid;
  logic [DW-1:0] odata;
  logic          busy, done, timeout_err;
  logic [15:0]   pass_cnt, fail_cnt;
  logic [IW-1:0] last_fail_id;

  logic [DW-1:0] rom_text [4];
  logic [DW-1:0] rom_key  [4];
  logic [DW-1:0] rom_exp  [4];

  logic [3:0]    corrupt_mask, badid_mask, mute_mask;
  logic          inj_ovalid;
  logic [IW-1:0] inj_id;
  logic [DW-1:0] inj_data;

  logic          mdl_ovalid = 1'b0;
  logic [IW-1:0] res_id     = '0;
  logic [DW-1:0] res_data   = '0;
  logic [DW-1:0] cap_text   = '0;
  int            lat_cnt    = 0;
  int            beat_n     = 0;
  logic [IW-1:0] b_tid   [64];
  logic          b_last  [64];
  logic [DW-1:0] b_data  [64];
  logic [1:0]    b_addr  [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sclk = ~sclk;

  aes_vector_driver #(
    .DATA_W(DW), .ID_W(IW), .NUM_VEC(4), .ADDR_W(2),
    .TID_BASE(1), .TIMEOUT_CYC(16), .CNT_W(16)
  ) dut (
    .sclk(sclk), .srst(srst), .start(start), .loop_en(loop_en),
    .vec_addr(vec_addr), .vec_text(vec_text), .vec_key(vec_key),
    .vec_expect(vec_expect), .tvalid(tvalid), .tlast(tlast), .tready(tready),
    .tid(tid), .tdata(tdata), .ovalid(ovalid), .oid(oid), .odata(odata),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout_err(timeout_err), .last_fail_id(last_fail_id)
  );

  // ROM read data follows vec_addr within the FETCH cycle.
  assign vec_text   = rom_text[vec_addr];
  assign vec_key    = rom_key[vec_addr];
  assign vec_expect = rom_exp[vec_addr];

  assign ovalid = mdl_ovalid | inj_ovalid;
  assign oid    = inj_ovalid ? inj_id   : res_id;
  assign odata  = inj_ovalid ? inj_data : res_data;

  function automatic logic [1:0] find_vec(input logic [DW-1:0] t);
    for (int i = 0; i < 4; i++) if (rom_text[i] == t) return 2'(i);
    return 2'd0;
  endfunction

  // Beat monitor and aes stand-in.
  always @(posedge sclk) begin
    mdl_ovalid <= 1'b0;
    if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) mdl_ovalid <= 1'b1;
    end
    if (tvalid && tready) begin
      b_tid[beat_n[5:0]]  <= tid;
      b_last[beat_n[5:0]] <= tlast;
      b_data[beat_n[5:0]] <= tdata;
      b_addr[beat_n[5:0]] <= vec_addr;
      beat_n <= beat_n + 1;
      if (!tlast) begin
        cap_text <= tdata;
      end else if (!mute_mask[find_vec(cap_text)]) begin
        lat_cnt  <= LAT;
        res_id   <= tid ^ (badid_mask[find_vec(cap_text)] ? 32'h100 : 32'h0);
        res_data <= rom_exp[find_vec(cap_text)] ^
                    (corrupt_mask[find_vec(cap_text)] ? 128'h1 : 128'h0);
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Compare nv vectors' beats starting at monitor index b0 against the ROM.
  task automatic check_beats(input string nm, input int b0, input int nv, input int tid0);
    int bad;
    bad = 0;
    for (int v = 0; v < nv; v++) begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        int a;
        idx = b0 + 2 * v + k;
        a   = v % 4;
        if (b_tid[idx[5:0]] !== 32'(tid0 + v)) bad++;
        if (b_last[idx[5:0]] !== (k == 1)) bad++;
        if (b_addr[idx[5:0]] !== a[1:0]) bad++;
        if (b_data[idx[5:0]] !== (k == 1 ? rom_key[a[1:0]] : rom_text[a[1:0]])) bad++;
      end
    end
    chki({nm, " beat errors"}, bad, 0);
  endtask

  // Pulse start, then run until busy drops; poke >= 0 re-pulses start mid-run.
  task automatic run_set(input int poke, output int dn, output bit ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      start = (i == poke);
      tick();
      if (done) dn++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_key(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tvalid && tlast) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [3:0]  corrupt;
    logic [3:0]  badid;
    logic [3:0]  mute;
    int          exp_pass;
    int          exp_fail;
    logic        exp_to;
    logic [31:0] exp_lfid;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int         dn;
    bit         ok;
    int         b0;
    int         n;
    logic [DW-1:0] d0;
    logic [IW-1:0] t0;
    bit         stable;

    rom_text[0] = 128'h3243f6a8885a308d313198a2e0370734;
    rom_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rom_exp[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
    rom_text[1] = 128'h00112233445566778899aabbccddeeff;
    rom_key[1]  = 128'h000102030405060708090a0b0c0d0e0f;
    rom_exp[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    rom_text[2] = 128'h11111111222222223333333344444444;
    rom_key[2]  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    rom_exp[2]  = 128'h0123456789abcdef0123456789abcdef;
    rom_text[3] = 128'hffeeddccbbaa99887766554433221100;
    rom_key[3]  = 128'h0f0e0d0c0b0a09080706050403020100;
    rom_exp[3]  = 128'hcafef00dcafef00dcafef00dcafef00d;

    //            corrupt  badid    mute     pass fail to    last_fail_id
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4,   0,   1'b0, 32'd0};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0000, 3,   1,   1'b0, 32'd3};
    tbl[2] = '{4'b0000, 4'b0010, 4'b0000, 3,   1,   1'b0, 32'd2};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0001, 3,   1,   1'b1, 32'd1};
    tbl[4] = '{4'b1001, 4'b0000, 4'b0000, 2,   2,   1'b0, 32'd4};

    srst = 1'b1; start = 1'b0; loop_en = 1'b0; tready = 1'b1;
    corrupt_mask = '0; badid_mask = '0; mute_mask = '0;
    inj_ovalid = 1'b0; inj_id = '0; inj_data = '0;

    // Reset state.
    repeat (3) tick();
    chki("rst tvalid", int'(tvalid), 0);
    chki("rst tlast", int'(tlast), 0);
    chki("rst tid", int'(tid), 1);
    chk("rst tdata", tdata, '0);
    chki("rst vec_addr", int'(vec_addr), 0);
    chki("rst busy", int'(busy), 0);
    chki("rst done", int'(done), 0);
    chki("rst pass_cnt", int'(pass_cnt), 0);
    chki("rst fail_cnt", int'(fail_cnt), 0);
    chki("rst timeout_err", int'(timeout_err), 0);
    chki("rst last_fail_id", int'(last_fail_id), 0);
    srst = 1'b0;
    tick();

    // Table-driven full passes over the 4-vector ROM.
    for (int s = 0; s < 5; s++) begin
      corrupt_mask = tbl[s].corrupt;
      badid_mask   = tbl[s].badid;
      mute_mask    = tbl[s].mute;
      b0 = beat_n;
      run_set(-1, dn, ok);
      chki($sformatf("s%0d finished", s), int'(ok), 1);
      chki($sformatf("s%0d done pulses", s), dn, 1);
      chki($sformatf("s%0d pass_cnt", s), int'(pass_cnt), tbl[s].exp_pass);
      chki($sformatf("s%0d fail_cnt", s), int'(fail_cnt), tbl[s].exp_fail);
      chki($sformatf("s%0d timeout_err", s), int'(timeout_err), int'(tbl[s].exp_to));
      chki($sformatf("s%0d last_fail_id", s), int'(last_fail_id), int'(tbl[s].exp_lfid));
      chki($sformatf("s%0d beat count", s), beat_n - b0, 8);
      check_beats($sformatf("s%0d", s), b0, 4, 1);
      repeat (3) tick();
      chki($sformatf("s%0d done after idle", s), int'(done), 0);
      chki($sformatf("s%0d pass held", s), int'(pass_cnt), tbl[s].exp_pass);
    end
    corrupt_mask = '0; badid_mask = '0; mute_mask = '0;

    // Back-pressure: 5 stalled cycles on TEXT, 3 on KEY.
    tready = 1'b0;
    b0 = beat_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chki("stall text offered", int'(ok), 1);
    d0 = tdata;
    t0 = tid;
    chk("stall text data", d0, rom_text[0]);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(tvalid && !tlast && tdata == d0 && tid == t0)) stable = 1'b0;
      tick();
    end
    chki("stall text stable", int'(stable), 1);
    chki("stall text none taken", beat_n - b0, 0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(tvalid && tlast && tdata == rom_key[0] && tid == t0)) stable = 1'b0;
      tick();
    end
    chki("stall key stable", int'(stable), 1);
    chki("stall one beat taken", beat_n - b0, 1);
    tready = 1'b1;
    wait_idle(ok);
    chki("stall finished", int'(ok), 1);
    chki("stall beat count", beat_n - b0, 8);
    check_beats("stall", b0, 4, 1);
    chki("stall pass_cnt", int'(pass_cnt), 4);

    // Timeout timing: vector 0 never answered.
    mute_mask = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_key(ok);
    chki("to key seen", int'(ok), 1);
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) break;
      tick();
      n++;
    end
    chki("to cycles to timeout_err", n, 16);
    chki("to fail before check", int'(fail_cnt), 0);
    tick();
    chki("to fail_cnt after check", int'(fail_cnt), 1);
    tick();
    chki("to next tvalid", int'(tvalid), 1);
    chki("to next tid", int'(tid), 2);
    wait_idle(ok);
    chki("to finished", int'(ok), 1);
    chki("to pass_cnt", int'(pass_cnt), 3);
    mute_mask = '0;

    // Looping, then reset during a key beat.
    loop_en = 1'b1;
    b0 = beat_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (beat_n - b0 >= 10) break;
      tick();
    end
    chki("loop beats reached", int'(beat_n - b0 >= 10), 1);
    check_beats("loop", b0, 5, 1);
    chki("loop busy", int'(busy), 1);
    wait_key(ok);
    chki("loop key seen", int'(ok), 1);
    chki("loop pass before rst", int'(int'(pass_cnt) >= 4), 1);
    tready = 1'b0;
    srst = 1'b1;
    tick();
    chki("mid rst tvalid", int'(tvalid), 0);
    chki("mid rst busy", int'(busy), 0);
    chki("mid rst pass_cnt", int'(pass_cnt), 0);
    chki("mid rst fail_cnt", int'(fail_cnt), 0);
    chki("mid rst tid", int'(tid), 1);
    chki("mid rst vec_addr", int'(vec_addr), 0);
    srst = 1'b0;
    tready = 1'b1;
    loop_en = 1'b0;
    repeat (8) tick();

    // start while busy is ignored; ovalid while idle changes nothing.
    b0 = beat_n;
    run_set(6, dn, ok);
    chki("poke finished", int'(ok), 1);
    chki("poke done pulses", dn, 1);
    chki("poke beat count", beat_n - b0, 8);
    check_beats("poke", b0, 4, 1);
    chki("poke pass_cnt", int'(pass_cnt), 4);
    inj_id = 32'd1;
    inj_data = rom_exp[0];
    inj_ovalid = 1'b1;
    tick();
    inj_ovalid = 1'b0;
    repeat (3) tick();
    chki("idle ovalid pass", int'(pass_cnt), 4);
    chki("idle ovalid fail", int'(fail_cnt), 0);
    chki("idle ovalid busy", int'(busy), 0);
    chki("idle ovalid tvalid", int'(tvalid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
